riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit between the RISC-V datapath's memory stage and the data memory. It takes the ALU-computed address, store data and funct3 for LB/LH/LW/LBU/LHU/SB/SH/SW, and checks alignment and funct3 legality. It drives a word-aligned memory request with byte enables over a req/ack handshake, then returns the sign- or zero-extended load result. It stalls the datapath until completion, which lets the core run against memories with variable latency.

Parameters:
TIMEOUT, 16, max cycles in ACCESS waiting for mem_ack before aborting with fault; 0 = never time out.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req  in  1  datapath requests memory op; held high until done
we  in  1  1 = store, 0 = load
funct3  in  3  RV32I load/store funct3
addr  in  32  byte address
wdata  in  32  store data (rs2)
rdata  out  32  extended load result, valid with done, held until next done
done  out  1  one-cycle completion pulse
busy  out  1  stall to datapath = req & ~done
fault  out  1  pulses with done: misaligned, illegal funct3 or timeout
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  32  {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory accepted/completed request
mem_rdata  in  32  memory read word, valid with mem_ack

Behaviour:
- Reset (sync, any state): state=IDLE. rdata=0, done=0, fault=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, timeout counter=0. A mem_ack arriving after reset is ignored.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, req=1, request legal: register mem_addr, mem_be, mem_wdata and mem_we; next state ACCESS.
- IDLE, req=1, request illegal: next state RESP with fault=1. No memory access.
- Illegal request: misaligned (half with addr[0]=1, word with addr[1:0]!=0) or illegal funct3 (load 3/6/7, store >=3).
- ACCESS: mem_req=1; addr, be, wdata and we stay stable until mem_ack. On mem_ack: capture extended load data (store: rdata unchanged), next state RESP.
- ACCESS timeout: counter increments each cycle without ack. If TIMEOUT!=0 and count reaches TIMEOUT: next state RESP with fault=1, mem_req drops, rdata unchanged.
- RESP: done=1 for exactly one cycle, then IDLE. req seen in RESP is not accepted; a new op starts from IDLE, earliest the cycle after done.
- Latency with zero-wait ack: req seen in IDLE at cycle N, mem_req at N+1, done at N+2. Fault path: done at N+1.
- Byte enables: byte = 1<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- Store data: byte replicated x4; half replicated x2; word as-is.
- Load extraction: select lane by addr[1:0] (byte) or addr[1] (half). LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- busy is combinational: high from req assertion until the cycle done=1, so the PC and register write are held.
- Simultaneous mem_ack and timeout in the same cycle: ack wins, no fault.

Test Plan:
1. mem_rdata=0xdeadbeef, zero-wait ack; LW addr 0x8 -> mem_addr=0x8, be=1111, mem_we=0; done 2 cycles after req; rdata=0xdeadbeef, fault=0.
2. Same memory word, loads: LB 0xB -> 0xffffffde; LBU 0xB -> 0x000000de; LH 0xA -> 0xffffdead; LHU 0x8 -> 0x0000beef.
3. SB addr 0x5, wdata 0x000000a5 -> mem_addr=0x4, be=0010, mem_wdata=0xa5a5a5a5, mem_we=1. SH addr 0x6, wdata 0x1234 -> be=1100, mem_wdata=0x12341234.
4. LW addr 0x6 -> done and fault 1 cycle after req, mem_req never high. funct3=3 load -> same result.
5. mem_ack delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles, done 1 cycle after ack. With TIMEOUT=4 and no ack -> fault+done after 4 ACCESS cycles, mem_req low afterwards.
6. rst pulsed mid-ACCESS -> next cycle mem_req=0, done=0, rdata=0. A mem_ack one cycle later produces no done; a fresh LW then completes normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu -- load/store unit between the memory stage and data memory.
//
// Accepts LB/LH/LW/LBU/LHU/SB/SH/SW requests, rejects misaligned or
// illegal-funct3 operations without touching memory, and otherwise issues
// a word-aligned request with byte enables over a req/ack handshake.
// Load data comes back sign- or zero-extended.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req, we, funct3  operation request (held until done), store flag, funct3
//   addr, wdata      byte address, store data (rs2)
//   rdata            extended load result, held until the next done
//   done, fault      one-cycle completion pulse, error flag alongside done
//   busy             datapath stall, req & ~done
//   mem_*            word-aligned memory request / handshake
module riscv_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Counter value on the last ACCESS cycle allowed before giving up.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ld_f3;
  logic [1:0]       ld_off;
  logic             f3_bad;
  logic             misalign;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    load_extract = 32'(b);          // LB: signed cast sign-extends
      3'd1:    load_extract = 32'(h);          // LH
      3'd4:    load_extract = {24'b0, b};      // LBU
      3'd5:    load_extract = {16'b0, h};      // LHU
      default: load_extract = w;               // LW
    endcase
  endfunction

  // Legal loads: 0,1,2,4,5. Legal stores: 0,1,2.
  assign f3_bad   = we ? (funct3[2] | (funct3[1:0] == 2'b11))
                       : ((funct3 == 3'd3) | (funct3 == 3'd6) | (funct3 == 3'd7));
  assign misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
                    ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

  assign busy = req & ~done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ld_f3     <= '0;
      ld_off    <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (f3_bad | misalign) begin
              state <= RESP;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= ACCESS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= byte_en(funct3, addr[1:0]);
              mem_wdata <= store_lanes(funct3, wdata);
              ld_f3     <= funct3;
              ld_off    <= addr[1:0];
            end
          end
        end
        ACCESS: begin
          // An ack on the final allowed cycle still completes normally.
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) rdata <= load_extract(ld_f3, ld_off, mem_rdata);
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            state   <= RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // RESP: done is visible this cycle; any req here waits for IDLE.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed testbench for riscv_lsu (built with TIMEOUT=4).
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        done, busy, fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from the most recent run_op.
  int          lat, req_cyc;
  logic [31:0] c_addr, c_wd, r_data;
  logic [3:0]  c_be;
  logic        c_we, stable, busy_ok, r_fault, r_mreq, done_after, mreq_after;

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Drives one operation starting just after a rising edge. ack_delay < 0
  // means the memory never acknowledges. Returns one cycle after done.
  task automatic run_op(input logic op_we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_delay);
    int wait_n = 0;
    bit got = 0;
    we = op_we; funct3 = f3; addr = a; wdata = wd; req = 1'b1; mem_ack = 1'b0;
    lat = 0; req_cyc = 0; stable = 1'b1; busy_ok = 1'b1;
    #1;
    if (busy !== 1'b1) busy_ok = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      mem_ack = 1'b0;
      if (done === 1'b1) begin
        got = 1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (mem_req === 1'b1) begin
          if (req_cyc == 0) begin
            c_addr = mem_addr; c_be = mem_be; c_wd = mem_wdata; c_we = mem_we;
          end else if (c_addr !== mem_addr || c_be !== mem_be || c_wd !== mem_wdata ||
                       c_we !== mem_we) begin
            stable = 1'b0;
          end
          req_cyc++;
          if (ack_delay >= 0 && wait_n == ack_delay) mem_ack = 1'b1;
          wait_n++;
        end
      end
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    r_data = rdata; r_fault = fault; r_mreq = mem_req;
    req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    done_after = done; mreq_after = mem_req;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", fault); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_cmp++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin n_bad++;
      $display("FAIL reset_mem_bus got we=%b be=%b addr=%h wd=%h want all 0", mem_we, mem_be, mem_addr, mem_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    mem_rdata = 32'hdeadbeef;
    run_op(1'b0, 3'd2, 32'h8, 32'h0, 0);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency got %0d want 2", lat); end
    n_cmp++; if (c_addr !== 32'h8) begin n_bad++; $display("FAIL lw_mem_addr got %h want 00000008", c_addr); end
    n_cmp++; if (c_be !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b want 1111", c_be); end
    n_cmp++; if (c_we !== 1'b0) begin n_bad++; $display("FAIL lw_mem_we got %b want 0", c_we); end
    n_cmp++; if (r_data !== 32'hdeadbeef) begin n_bad++; $display("FAIL lw_rdata got %h want deadbeef", r_data); end
    n_cmp++; if (r_fault !== 1'b0) begin n_bad++; $display("FAIL lw_fault got %b want 0", r_fault); end
    n_cmp++; if (busy_ok !== 1'b1) begin n_bad++; $display("FAIL lw_busy got %b want 1", busy_ok); end
    n_cmp++; if (done_after !== 1'b0) begin n_bad++; $display("FAIL lw_done_pulse got %b want 0", done_after); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] as  [4] = '{32'hB, 32'hB, 32'hA, 32'h8};
    logic [31:0] exp [4] = '{32'hffffffde, 32'h000000de, 32'hffffdead, 32'h0000beef};
    logic [3:0]  bes [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
    mem_rdata = 32'hdeadbeef;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f3s[i], as[i], 32'h0, 0);
      n_cmp++; if (r_data !== exp[i]) begin n_bad++;
        $display("FAIL load_ext[%0d] rdata got %h want %h", i, r_data, exp[i]); end
      n_cmp++; if (c_be !== bes[i] || c_addr !== 32'h8) begin n_bad++;
        $display("FAIL load_ext[%0d] be/addr got %b/%h want %b/00000008", i, c_be, c_addr, bes[i]); end
      n_cmp++; if (lat !== 2 || r_fault !== 1'b0) begin n_bad++;
        $display("FAIL load_ext[%0d] lat/fault got %0d/%b want 2/0", i, lat, r_fault); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] as  [3] = '{32'h5, 32'h6, 32'h0};
    logic [31:0] wds [3] = '{32'h000000a5, 32'h00001234, 32'hcafef00d};
    logic [31:0] ead [3] = '{32'h4, 32'h4, 32'h0};
    logic [3:0]  ebe [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ewd [3] = '{32'ha5a5a5a5, 32'h12341234, 32'hcafef00d};
    mem_rdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, f3s[i], as[i], wds[i], 0);
      n_cmp++; if (c_addr !== ead[i]) begin n_bad++;
        $display("FAIL store[%0d] mem_addr got %h want %h", i, c_addr, ead[i]); end
      n_cmp++; if (c_be !== ebe[i]) begin n_bad++;
        $display("FAIL store[%0d] be got %b want %b", i, c_be, ebe[i]); end
      n_cmp++; if (c_wd !== ewd[i]) begin n_bad++;
        $display("FAIL store[%0d] mem_wdata got %h want %h", i, c_wd, ewd[i]); end
      n_cmp++; if (c_we !== 1'b1) begin n_bad++;
        $display("FAIL store[%0d] mem_we got %b want 1", i, c_we); end
      // Last load returned LHU 0x8 -> 0000beef; stores must leave it alone.
      n_cmp++; if (r_data !== 32'h0000beef || r_fault !== 1'b0) begin n_bad++;
        $display("FAIL store[%0d] rdata/fault got %h/%b want 0000beef/0", i, r_data, r_fault); end
    end
  endtask

  task automatic test_illegal();
    logic        wes [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s [5] = '{3'd2, 3'd3, 3'd1, 3'd4, 3'd5};
    logic [31:0] as  [5] = '{32'h6, 32'h0, 32'h3, 32'h0, 32'h1};
    for (int i = 0; i < 5; i++) begin
      run_op(wes[i], f3s[i], as[i], 32'hffffffff, 0);
      n_cmp++; if (lat !== 1 || r_fault !== 1'b1) begin n_bad++;
        $display("FAIL illegal[%0d] lat/fault got %0d/%b want 1/1", i, lat, r_fault); end
      n_cmp++; if (req_cyc !== 0) begin n_bad++;
        $display("FAIL illegal[%0d] mem_req_cycles got %0d want 0", i, req_cyc); end
      n_cmp++; if (r_data !== 32'h0000beef || busy_ok !== 1'b1) begin n_bad++;
        $display("FAIL illegal[%0d] rdata/busy got %h/%b want 0000beef/1", i, r_data, busy_ok); end
    end
  endtask

  task automatic test_wait_and_timeout();
    // Ack lands on the final allowed cycle: ack wins over timeout.
    mem_rdata = 32'h80000001;
    run_op(1'b0, 3'd2, 32'h10, 32'h0, 3);
    n_cmp++; if (req_cyc !== 4 || stable !== 1'b1) begin n_bad++;
      $display("FAIL wait_req got cycles=%0d stable=%b want 4/1", req_cyc, stable); end
    n_cmp++; if (lat !== 5 || c_addr !== 32'h10) begin n_bad++;
      $display("FAIL wait_lat got lat=%0d addr=%h want 5/00000010", lat, c_addr); end
    n_cmp++; if (r_fault !== 1'b0 || r_data !== 32'h80000001) begin n_bad++;
      $display("FAIL wait_result got fault=%b rdata=%h want 0/80000001", r_fault, r_data); end
    // No ack at all.
    mem_rdata = 32'h0badf00d;
    run_op(1'b0, 3'd2, 32'h20, 32'h0, -1);
    n_cmp++; if (req_cyc !== 4 || lat !== 5) begin n_bad++;
      $display("FAIL timeout_timing got cycles=%0d lat=%0d want 4/5", req_cyc, lat); end
    n_cmp++; if (r_fault !== 1'b1) begin n_bad++; $display("FAIL timeout_fault got %b want 1", r_fault); end
    n_cmp++; if (r_mreq !== 1'b0 || mreq_after !== 1'b0) begin n_bad++;
      $display("FAIL timeout_mem_req got %b/%b want 0/0", r_mreq, mreq_after); end
    n_cmp++; if (r_data !== 32'h80000001) begin n_bad++;
      $display("FAIL timeout_rdata got %h want 80000001", r_data); end
  endtask

  task automatic test_reset_mid_access();
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h0; mem_ack = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_start got %b want 1", mem_req); end
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_req !== 1'b0 || done !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_ctrl got req=%b done=%b want 0/0", mem_req, done); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata got %h want 0", rdata); end
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hffffffff;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_cmp++; if (done !== 1'b0 || rdata !== 32'h0) begin n_bad++;
      $display("FAIL rstmid_stale_ack got done=%b rdata=%h want 0/0", done, rdata); end
    @(posedge clk); #1;
    mem_rdata = 32'h13572468;
    run_op(1'b0, 3'd2, 32'hc, 32'h0, 0);
    n_cmp++; if (lat !== 2 || r_data !== 32'h13572468 || r_fault !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_fresh got lat=%0d rdata=%h fault=%b want 2/13572468/0", lat, r_data, r_fault); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_illegal();
    test_wait_and_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
